// File: rtl/bias_buf_ctrl_if.sv
// Load and burst-read handshake bundle for bias_buf_ctrl.
// The design connects through slave; the load/request source connects through master.
interface bias_buf_ctrl_if #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 6
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W:0]   rd_len;
  logic              rd_busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              done;
  logic              err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len,
    input  wr_ready, rd_busy, out_valid, out_data, out_last, done, err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len,
    output wr_ready, rd_busy, out_valid, out_data, out_last, done, err
  );
endinterface

// File: rtl/bias_buf_ctrl.sv
// Bias word buffer: loads words into a RAM, then streams a range out; each word leaves RD_LAT cycles after its read.
// Loads are accepted only while idle with no burst request; the output stream cannot be stalled.
module bias_buf_ctrl #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 49,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  bias_buf_ctrl_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              err_q;

  logic              wr_rdy, start_ok, start_bad, issue, issue_last;
  logic              wr_hs, wr_in_range;
  logic [ADDR_W:0]   rd_end;
  logic              req_ok;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] vld_pipe, last_pipe;
  logic [DATA_W-1:0] dat_pipe [RD_LAT];
  logic              out_vld, out_lst;

  // Extra bit keeps base+len from wrapping; the len bound keeps the sum within it.
  assign rd_end = {1'b0, bus.rd_base} + bus.rd_len;
  assign req_ok = (bus.rd_len != '0) && (bus.rd_len <= DEPTH_W) && (rd_end <= DEPTH_W);

  assign wr_hs       = bus.wr_valid & bus.wr_ready;
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);

  always_comb begin
    state_d    = state_q;
    wr_rdy     = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        wr_rdy = ~bus.rd_start;
        if (bus.rd_start) begin
          if (req_ok) begin
            start_ok = 1'b1;
            state_d  = READ;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      READ: begin
        issue = 1'b1;
        if (rem_q == ONE_W) begin
          issue_last = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (out_vld && out_lst) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad | (wr_hs & ~wr_in_range);
      if (start_ok) begin
        addr_q <= bus.rd_base;
        rem_q  <= bus.rd_len;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - ONE_W;
      end
    end
  end

  // Storage is deliberately not reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (wr_hs && wr_in_range) mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (issue) dat_pipe[0] <= mem[addr_q[IDX_W-1:0]];
    for (int i = 1; i < RD_LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[RD_LAT-1];
  assign out_lst = out_vld & last_pipe[RD_LAT-1];

  assign bus.wr_ready  = wr_rdy & rst_n;
  assign bus.rd_busy   = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.out_valid = out_vld;
  assign bus.out_last  = out_lst;
  assign bus.out_data  = out_vld ? dat_pipe[RD_LAT-1] : '0;
endmodule

// File: tb/tb_bias_buf_ctrl.sv
// Bench for bias_buf_ctrl: two configurations, scoreboard-checked bursts against a queue/array reference.
module tb_bias_buf_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bias_buf_ctrl_if #(.DATA_W(40), .ADDR_W(6)) ifa();
  bias_buf_ctrl_if #(.DATA_W(16), .ADDR_W(6)) ifb();

  bias_buf_ctrl #(.DATA_W(40), .DEPTH(49), .ADDR_W(6), .RD_LAT(2))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bias_buf_ctrl #(.DATA_W(16), .DEPTH(8), .ADDR_W(6), .RD_LAT(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic        sel = 1'b0;
  logic        wr_valid = 1'b0, rd_start = 1'b0;
  logic [5:0]  wr_addr = '0, rd_base = '0;
  logic [39:0] wr_data = '0;
  logic [6:0]  rd_len = '0;

  assign ifa.wr_valid = wr_valid & ~sel;
  assign ifa.rd_start = rd_start & ~sel;
  assign ifa.wr_addr  = wr_addr;
  assign ifa.wr_data  = wr_data;
  assign ifa.rd_base  = rd_base;
  assign ifa.rd_len   = rd_len;
  assign ifb.wr_valid = wr_valid & sel;
  assign ifb.rd_start = rd_start & sel;
  assign ifb.wr_addr  = wr_addr;
  assign ifb.wr_data  = wr_data[15:0];
  assign ifb.rd_base  = rd_base;
  assign ifb.rd_len   = rd_len;

  logic        o_vld, o_last, o_done, o_err, o_busy, o_wrdy;
  logic [39:0] o_dat;
  assign o_vld  = sel ? ifb.out_valid : ifa.out_valid;
  assign o_last = sel ? ifb.out_last  : ifa.out_last;
  assign o_done = sel ? ifb.done      : ifa.done;
  assign o_err  = sel ? ifb.err       : ifa.err;
  assign o_busy = sel ? ifb.rd_busy   : ifa.rd_busy;
  assign o_wrdy = sel ? ifb.wr_ready  : ifa.wr_ready;
  assign o_dat  = sel ? {24'd0, ifb.out_data} : ifa.out_data;

  typedef struct packed {
    logic [39:0] d;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [39:0] mdl [2][64];
  int          depth = 49, lat = 2;
  logic [39:0] mask = 40'hFF_FFFF_FFFF;
  int          total = 0, bad = 0, pops = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented word must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_vld) begin
        if (q.size() == 0) chk("out_valid_unexpected", o_vld, 1'b0);
        else begin
          exp_t e;
          e = q.pop_front();
          pops++;
          chk("out_data", o_dat, e.d);
          chk("out_last", o_last, e.last);
        end
      end else begin
        chk("idle_data_zero", o_dat, 40'd0);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_burst(input int base, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d    = mdl[sel][base+i];
      e.last = (i == len-1);
      q.push_back(e);
    end
  endtask

  task automatic do_write(input int a, input logic [39:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a[5:0]; wr_data = d;
    while (!o_wrdy && n < 100) begin tick; n++; end
    if (!o_wrdy) begin
      chk("wr_ready_timeout", o_wrdy, 1'b1);
      wr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (a < depth) mdl[sel][a] = d & mask;
    tick;
    wr_valid = 1'b0;
    chk("wr_err", o_err, a >= depth);
  endtask

  task automatic do_burst(input int base, input int len, input bit poke);
    bit ok;
    int k, errs;
    ok = (len >= 1) && (base + len <= depth);
    if (ok) push_burst(base, len);
    rd_start = 1'b1; rd_base = base[5:0]; rd_len = len[6:0];
    tick;
    rd_start = 1'b0;
    chk("req_err", o_err, !ok);
    chk("rd_busy_start", o_busy, ok);
    if (ok) begin
      k = 1; errs = 0;
      while (!o_done && k < 300) begin
        if (poke && k == 2) begin rd_start = 1'b1; rd_len = '0; end
        tick;
        rd_start = 1'b0;
        k++;
        if (o_err) errs++;
      end
      chk("done_latency", k, len + lat + 1);
      chk("busy_at_done", o_busy, 1'b1);
      chk("ignored_start_err", errs, 0);
      chk("queue_drained", q.size(), 0);
      tick;
      chk("busy_clear", o_busy, 1'b0);
    end else begin
      repeat (3) begin
        tick;
        chk("busy_after_reject", o_busy, 1'b0);
      end
    end
  endtask

  task automatic random_ops(input int n);
    logic [63:0] t;
    int r, b, l;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        t = {$urandom(), $urandom()};
        do_write($urandom_range(0, depth + 2), t[39:0]);
      end else begin
        b = $urandom_range(0, depth - 1);
        l = $urandom_range(0, depth - b + 1);
        do_burst(b, l, r == 9);
      end
    end
  endtask

  initial begin
    int k;
    repeat (3) tick;
    chk("rst_out_valid", o_vld, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_wr_ready", o_wrdy, 1'b0);
    chk("rst_err", o_err, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("wr_ready_after_rst", o_wrdy, 1'b1);

    for (int a = 0; a < 49; a++) do_write(a, 40'h01_0000_0000 + 40'(a));
    do_burst(0, 49, 1'b0);
    do_burst(45, 5, 1'b0);
    do_burst(45, 4, 1'b0);
    do_write(49, 40'hDE_ADBE_EF00);
    do_burst(48, 1, 1'b0);

    // Collision: burst wins, write waits until the FSM is back in IDLE.
    push_burst(0, 49);
    rd_start = 1'b1; rd_base = 6'd0; rd_len = 7'd49;
    wr_valid = 1'b1; wr_addr = 6'd10; wr_data = 40'hAB_CDEF_0123;
    #1;
    chk("wr_ready_collision", o_wrdy, 1'b0);
    tick;
    rd_start = 1'b0;
    k = 1;
    while (!o_wrdy && k < 300) begin tick; k++; end
    chk("collision_wr_wait", k, 49 + lat + 2);
    @(posedge clk);
    mdl[0][10] = 40'hAB_CDEF_0123;
    tick;
    wr_valid = 1'b0;
    chk("collision_wr_err", o_err, 1'b0);
    chk("collision_drained", q.size(), 0);
    do_burst(8, 4, 1'b0);

    // Reset after three words of a full burst.
    push_burst(0, 49);
    rd_start = 1'b1; rd_base = 6'd0; rd_len = 7'd49;
    tick;
    rd_start = 1'b0;
    k = 0;
    while (pops < 3 + 49 + 49 + 4 + 4 + 1 + 49 - 49 && k < 0) k++;
    k = pops;
    for (int n = 0; n < 20 && pops < k + 3; n++) tick;
    chk("mid_burst_words", pops - k, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", o_vld, 1'b0);
    chk("rst_mid_data", o_dat, 40'd0);
    chk("rst_mid_last", o_last, 1'b0);
    chk("rst_mid_busy", o_busy, 1'b0);
    chk("rst_mid_done", o_done, 1'b0);
    chk("rst_mid_err", o_err, 1'b0);
    chk("rst_mid_wr_ready", o_wrdy, 1'b0);
    q.delete();
    tick;
    rst_n = 1'b1;
    #1;
    chk("wr_ready_release", o_wrdy, 1'b1);
    repeat (6) tick;
    do_burst(0, 49, 1'b0);
    random_ops(40);

    sel = 1'b1; depth = 8; lat = 1; mask = 40'h00_0000_FFFF;
    tick;
    for (int a = 0; a < 8; a++) do_write(a, 40'h00_0000_B000 + 40'(a));
    do_burst(0, 8, 1'b0);
    do_burst(5, 4, 1'b0);
    do_write(8, 40'h00_0000_1234);
    do_burst(0, 0, 1'b0);
    do_burst(4, 4, 1'b1);
    random_ops(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
